// File: rtl/coproc_alu_exec.sv
// coproc_alu_exec: execution stage behind the 3-byte command deframer.
// Takes one {num_1, num_2, opcode} command per i_start. It computes a 16-bit
// result, using one cycle for logic ops and 8 iterations for MUL and DIV.
// The result is sent high byte first over a valid/ready byte handshake.
// Optional build macro COPROC_STATUS_BYTE_EN prepends a status byte
// {6'b0, div_by_zero, illegal_opcode} to every result.
module coproc_alu_exec #(
  parameter int MUL_DIV_ITER = 8
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_num_1,
  input  logic [7:0] i_num_2,
  input  logic [7:0] i_opcode,
  input  logic       i_tx_ready,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_MUL = 8'h05;
  localparam logic [7:0] OP_DIV = 8'h06;
  localparam logic [7:0] OP_CMP = 8'h07;
  localparam logic [3:0] LAST_ITER = 4'(MUL_DIV_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_SEND_HI = 3'd2,
`ifdef COPROC_STATUS_BYTE_EN
    S_SEND_ST = 3'd4,
`endif
    S_SEND_LO = 3'd3
  } state_t;

  // One shift-add step: acc = {partial_hi, multiplier_remaining}.
  function automatic logic [15:0] mul_step(input logic [15:0] acc, input logic [7:0] a);
    logic [8:0] sum;
    if (acc[0]) begin
      sum = {1'b0, acc[15:8]} + {1'b0, a};
    end else begin
      sum = {1'b0, acc[15:8]};
    end
    return {sum, acc[7:1]};
  endfunction

  // One restoring-division step: acc = {remainder, dividend/quotient}.
  function automatic logic [15:0] div_step(input logic [15:0] acc, input logic [7:0] b);
    logic [8:0] rem_sh;
    logic [7:0] rem;
    logic       qbit;
    rem_sh = {acc[15:8], acc[7]};
    if (rem_sh >= {1'b0, b}) begin
      rem  = rem_sh[7:0] - b;
      qbit = 1'b1;
    end else begin
      rem  = rem_sh[7:0];
      qbit = 1'b0;
    end
    return {rem, acc[6:0], qbit};
  endfunction

  // Single-cycle operations; anything outside them yields all ones.
  function automatic logic [15:0] alu_single(input logic [7:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  return {7'd0, sum};
      OP_SUB:  return {8'h00, a} - {8'h00, b};
      OP_AND:  return {8'h00, a & b};
      OP_OR:   return {8'h00, a | b};
      OP_XOR:  return {8'h00, a ^ b};
      OP_CMP:  return (a == b) ? 16'h0000 : ((a > b) ? 16'h0001 : 16'h0002);
      default: return 16'hFFFF;
    endcase
  endfunction

  state_t      r_state, w_nx_state;
  logic [7:0]  r_a, r_b, r_op, w_nx_a, w_nx_b, w_nx_op;
  logic [3:0]  r_cnt, w_nx_cnt;
  logic [15:0] r_acc, w_nx_acc;
  logic [7:0]  r_res_lo, w_nx_res_lo;
`ifdef COPROC_STATUS_BYTE_EN
  logic [7:0]  r_res_hi, w_nx_res_hi;
`endif
  logic        r_tx_valid, w_nx_tx_valid;
  logic [7:0]  r_tx_data, w_nx_tx_data;
  logic        r_busy, w_nx_busy;
  logic        r_err, w_nx_err;

  logic        w_is_iter, w_div_zero, w_illegal, w_exec_done;
  logic [15:0] w_iter_acc, w_result;

  // Operation decode and the result ready at the end of EXEC.
  always_comb begin
    w_is_iter   = (r_op == OP_MUL) || (r_op == OP_DIV);
    w_div_zero  = (r_op == OP_DIV) && (r_b == 8'h00);
    w_illegal   = (r_op > OP_CMP);
    w_iter_acc  = (r_op == OP_MUL) ? mul_step(r_acc, r_a) : div_step(r_acc, r_b);
    w_exec_done = w_is_iter ? (r_cnt == LAST_ITER) : 1'b1;
    if (w_is_iter) begin
      w_result = w_div_zero ? 16'hFFFF : w_iter_acc;
    end else begin
      w_result = alu_single(r_op, r_a, r_b);
    end
  end

  // Next-state and next-output logic for the command FSM.
  always_comb begin
    w_nx_state    = r_state;
    w_nx_a        = r_a;
    w_nx_b        = r_b;
    w_nx_op       = r_op;
    w_nx_cnt      = r_cnt;
    w_nx_acc      = r_acc;
    w_nx_res_lo   = r_res_lo;
`ifdef COPROC_STATUS_BYTE_EN
    w_nx_res_hi   = r_res_hi;
`endif
    w_nx_tx_valid = r_tx_valid;
    w_nx_tx_data  = r_tx_data;
    w_nx_busy     = r_busy;
    w_nx_err      = r_err;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nx_a     = i_num_1;
          w_nx_b     = i_num_2;
          w_nx_op    = i_opcode;
          w_nx_cnt   = 4'd0;
          // Multiplier starts from B in the low half, divider from A.
          w_nx_acc   = (i_opcode == OP_DIV) ? {8'h00, i_num_1} : {8'h00, i_num_2};
          w_nx_busy  = 1'b1;
          w_nx_err   = 1'b0;
          w_nx_state = S_EXEC;
        end else begin
          w_nx_state = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_is_iter) begin
          w_nx_acc = w_iter_acc;
          w_nx_cnt = r_cnt + 4'd1;
        end else begin
          w_nx_acc = r_acc;
        end
        if (w_exec_done) begin
          w_nx_res_lo   = w_result[7:0];
          w_nx_err      = w_div_zero | w_illegal;
          w_nx_tx_valid = 1'b1;
`ifdef COPROC_STATUS_BYTE_EN
          w_nx_res_hi   = w_result[15:8];
          w_nx_tx_data  = {6'b000000, w_div_zero, w_illegal};
          w_nx_state    = S_SEND_ST;
`else
          w_nx_tx_data  = w_result[15:8];
          w_nx_state    = S_SEND_HI;
`endif
        end else begin
          w_nx_state = S_EXEC;
        end
      end
`ifdef COPROC_STATUS_BYTE_EN
      S_SEND_ST: begin
        if (i_tx_ready) begin
          w_nx_tx_data = r_res_hi;
          w_nx_state   = S_SEND_HI;
        end else begin
          w_nx_state = S_SEND_ST;
        end
      end
`endif
      S_SEND_HI: begin
        if (i_tx_ready) begin
          w_nx_tx_data = r_res_lo;
          w_nx_state   = S_SEND_LO;
        end else begin
          w_nx_state = S_SEND_HI;
        end
      end
      S_SEND_LO: begin
        if (i_tx_ready) begin
          w_nx_tx_valid = 1'b0;
          w_nx_busy     = 1'b0;
          w_nx_state    = S_IDLE;
        end else begin
          w_nx_state = S_SEND_LO;
        end
      end
      default: begin
        w_nx_tx_valid = 1'b0;
        w_nx_busy     = 1'b0;
        w_nx_state    = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_op       <= 8'h00;
      r_cnt      <= 4'd0;
      r_acc      <= 16'h0000;
      r_res_lo   <= 8'h00;
`ifdef COPROC_STATUS_BYTE_EN
      r_res_hi   <= 8'h00;
`endif
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nx_state;
      r_a        <= w_nx_a;
      r_b        <= w_nx_b;
      r_op       <= w_nx_op;
      r_cnt      <= w_nx_cnt;
      r_acc      <= w_nx_acc;
      r_res_lo   <= w_nx_res_lo;
`ifdef COPROC_STATUS_BYTE_EN
      r_res_hi   <= w_nx_res_hi;
`endif
      r_tx_valid <= w_nx_tx_valid;
      r_tx_data  <= w_nx_tx_data;
      r_busy     <= w_nx_busy;
      r_err      <= w_nx_err;
    end
  end

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule
